// File: rtl/spectral_bin_shifter.sv
// Pitch-shift stage: walks output bins k, reads two neighbouring source bins at k*ratio
// and writes their linear interpolation to the output RAM, 4 clocks per bin.
module spectral_bin_shifter #(
  parameter int N_LOG2     = 9,
  parameter int DW         = 18,
  parameter int RATIO_W    = 16,
  parameter int RATIO_FRAC = 12,
  parameter int FRAC_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [RATIO_W-1:0]  ratio,
  output logic                busy,
  output logic                done,
  output logic [N_LOG2-1:0]   src_addr,
  input  logic [2*DW-1:0]     src_data,
  output logic [N_LOG2-1:0]   dst_addr,
  output logic [2*DW-1:0]     dst_data,
  output logic                dst_we
);

  localparam int POS_W = N_LOG2 + 4 + RATIO_FRAC;
  localparam int IDX_W = POS_W - RATIO_FRAC;
  localparam int PW    = DW + FRAC_W + 2;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_ADDR0 = 6'b000010,
    S_ADDR1 = 6'b000100,
    S_CAP1  = 6'b001000,
    S_WRITE = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  state_t              state_q, state_d;
  logic [RATIO_W-1:0]  ratio_q, ratio_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [N_LOG2-1:0]   k_q, k_d;
  logic [2*DW-1:0]     a0_q, a0_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N_LOG2-1:0]   src_addr_q, src_addr_d;
  logic [N_LOG2-1:0]   dst_addr_q, dst_addr_d;
  logic [2*DW-1:0]     dst_data_q, dst_data_d;
  logic                dst_we_q, dst_we_d;

  logic [IDX_W-1:0]    idx;
  logic [FRAC_W-1:0]   frac;
  logic                out_of_range;
  logic [POS_W-1:0]    pos_next;

  // a0 + floor((a1 - a0) * f / 2^FRAC_W); result always lies between a0 and a1
  function automatic logic [DW-1:0] lerp(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                         input logic [FRAC_W-1:0] f);
    logic signed [DW:0]   d;
    logic signed [PW-1:0] p;
    d = $signed({a1[DW-1], a1}) - $signed({a0[DW-1], a0});
    p = PW'(d) * PW'($signed({1'b0, f}));
    p = p >>> FRAC_W;
    return a0 + p[DW-1:0];
  endfunction

  assign idx          = pos_q[POS_W-1:RATIO_FRAC];
  assign frac         = pos_q[RATIO_FRAC-1 -: FRAC_W];
  assign out_of_range = (idx >= IDX_W'((1 << N_LOG2) - 1));
  assign pos_next     = pos_q + POS_W'(ratio_q);

  always_comb begin
    state_d    = state_q;
    ratio_d    = ratio_q;
    pos_d      = pos_q;
    k_d        = k_q;
    a0_d       = a0_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    dst_we_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ADDR0;
          ratio_d    = ratio;
          pos_d      = '0;
          k_d        = '0;
          busy_d     = 1'b1;
          src_addr_d = '0;
        end
      end
      S_ADDR0: begin
        src_addr_d = idx[N_LOG2-1:0] + 1'b1;
        state_d    = S_ADDR1;
      end
      S_ADDR1: begin
        a0_d    = src_data;
        state_d = S_CAP1;
      end
      // src_data here is the upper neighbour a1; the result is registered for WRITE
      S_CAP1: begin
        dst_we_d   = 1'b1;
        dst_addr_d = k_q;
        if (out_of_range) begin
          dst_data_d = '0;
        end else begin
          dst_data_d = {lerp(a0_q[2*DW-1:DW], src_data[2*DW-1:DW], frac),
                        lerp(a0_q[DW-1:0],    src_data[DW-1:0],    frac)};
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (k_q == '1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          k_d        = k_q + 1'b1;
          pos_d      = pos_next;
          src_addr_d = pos_next[RATIO_FRAC +: N_LOG2];
          state_d    = S_ADDR0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ratio_q    <= '0;
      pos_q      <= '0;
      k_q        <= '0;
      a0_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      pos_q      <= pos_d;
      k_q        <= k_d;
      a0_q       <= a0_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      dst_we_q   <= dst_we_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_we   = dst_we_q;

endmodule
